// File: rtl/key_hash_if.sv
// Key-word stream and hash-result signals of the key hash unit.
// The bench drives through master; key_hash_unit is the slave.
interface key_hash_if;
   logic [31:0] in_word;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [63:0] key_hash;
   logic        key_en;
   logic        key_err;

   modport master (
      output in_word, in_valid, in_last,
      input  in_ready, key_hash, key_en, key_err
   );

   modport slave (
      input  in_word, in_valid, in_last,
      output in_ready, key_hash, key_en, key_err
   );
endinterface

// File: rtl/key_hash_unit.sv
// Absorbs a variable-length stream of 32-bit key words into a 64-bit hash.
// Keys longer than MAX_WORDS are drained and reported on key_err instead of key_en.
//
// state  | meaning
// ABSORB | accepting key words, mixing them into h
// FINAL  | last word absorbed; finalize h into key_hash
// OUT    | key_en visible; reload IV for the next key
// DRAIN  | key too long; discard words up to and including in_last
module key_hash_unit #(
   parameter int          MAX_WORDS = 8,
   parameter logic [63:0] HASH_IV   = 64'h0,
   parameter logic [31:0] SALT      = 32'h5A5A5A5A
) (
   input logic        clk,
   input logic        rst,
   key_hash_if.slave  bus
);

   localparam logic [7:0] MAX_CNT = 8'(MAX_WORDS);

   typedef enum logic [1:0] {
      ABSORB = 2'd0,
      FINAL  = 2'd1,
      OUT    = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   state_t      state, state_nx;
   logic [63:0] h, h_nx;
   logic [7:0]  cnt, cnt_nx;
   logic [63:0] key_hash_q;
   logic        key_en_q, key_en_nx;
   logic        key_err_q, key_err_nx;
   logic        accept;
   logic [63:0] mix_t, mix_h, fin_h;

   assign bus.in_ready = (state == ABSORB) || (state == DRAIN);
   assign accept       = bus.in_valid && bus.in_ready;

   // mix: xor the word into both halves (low half salted), then rotate left by 13
   assign mix_t = h ^ {bus.in_word, bus.in_word ^ SALT};
   assign mix_h = {mix_t[50:0], mix_t[63:51]};
   assign fin_h = h ^ {h[31:0], h[63:32]};

   always_comb begin
      state_nx   = state;
      h_nx       = h;
      cnt_nx     = cnt;
      key_en_nx  = 1'b0;
      key_err_nx = 1'b0;
      case (state)
         ABSORB: begin
            if (accept) begin
               // cnt is compared before increment, so it never wraps
               if (cnt == MAX_CNT) begin
                  if (bus.in_last) begin
                     key_err_nx = 1'b1;
                     h_nx       = HASH_IV;
                     cnt_nx     = 8'd0;
                  end else begin
                     state_nx = DRAIN;
                  end
               end else begin
                  h_nx   = mix_h;
                  cnt_nx = cnt + 8'd1;
                  if (bus.in_last) state_nx = FINAL;
               end
            end
         end
         FINAL: begin
            key_en_nx = 1'b1;
            state_nx  = OUT;
         end
         OUT: begin
            h_nx     = HASH_IV;
            cnt_nx   = 8'd0;
            state_nx = ABSORB;
         end
         DRAIN: begin
            if (accept && bus.in_last) begin
               key_err_nx = 1'b1;
               h_nx       = HASH_IV;
               cnt_nx     = 8'd0;
               state_nx   = ABSORB;
            end
         end
         default: state_nx = ABSORB;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ABSORB;
         h          <= HASH_IV;
         cnt        <= 8'd0;
         key_hash_q <= 64'h0;
         key_en_q   <= 1'b0;
         key_err_q  <= 1'b0;
      end else begin
         state     <= state_nx;
         h         <= h_nx;
         cnt       <= cnt_nx;
         key_en_q  <= key_en_nx;
         key_err_q <= key_err_nx;
         if (state == FINAL) key_hash_q <= fin_h;
      end
   end

   assign bus.key_hash = key_hash_q;
   assign bus.key_en   = key_en_q;
   assign bus.key_err  = key_err_q;

endmodule

// File: tb/tb_key_hash_unit.sv
// Self-checking bench for key_hash_unit: directed keys plus random keys with
// random valid gaps, checked against a word-list reference model and strobe scoreboard.
module tb_key_hash_unit;

   localparam int          MAX_WORDS = 8;
   localparam logic [63:0] HASH_IV   = 64'h0;
   localparam logic [31:0] SALT      = 32'h5A5A5A5A;
   localparam logic [63:0] H_ZERO1   = 64'h4B4B4B4B_4B4B4B4B;

   typedef logic [31:0] word_q_t[$];
   typedef struct {
      bit          is_err;
      logic [63:0] hash;
      int          cyc;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   started = 1'b0;
   logic [63:0] exp_hash = 64'h0;
   ev_t  exp_q[$];

   key_hash_if bus ();

   key_hash_unit #(
      .MAX_WORDS (MAX_WORDS),
      .HASH_IV   (HASH_IV),
      .SALT      (SALT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [63:0] mix(input logic [63:0] h, input logic [31:0] w);
      logic [63:0] t;
      t = h ^ {w, w ^ SALT};
      return (t << 13) | (t >> 51);
   endfunction

   function automatic logic [63:0] ref_hash(input word_q_t words);
      logic [63:0] h;
      h = HASH_IV;
      foreach (words[i]) h = mix(h, words[i]);
      return h ^ {h[31:0], h[63:32]};
   endfunction

   // strobe scoreboard: every strobe must match the oldest expected event
   always @(negedge clk) begin
      if (started && !rst) begin
         if (bus.key_en || bus.key_err) begin
            if (exp_q.size() == 0) begin
               check_eq("spurious_strobe", {62'h0, bus.key_en, bus.key_err}, 64'h0);
            end else begin
               ev_t e;
               e = exp_q.pop_front();
               check_eq("strobe_kind", {62'h0, bus.key_en, bus.key_err},
                        e.is_err ? 64'h1 : 64'h2);
               check_eq("strobe_cycle", 64'(cyc), 64'(e.cyc));
               if (!e.is_err) begin
                  check_eq("key_hash", bus.key_hash, e.hash);
                  exp_hash = e.hash;
               end
            end
         end else begin
            check_eq("key_hash_hold", bus.key_hash, exp_hash);
         end
      end
   end

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) begin
         bus.in_word = $urandom;
         bus.in_last = 1'($urandom);
         @(negedge clk);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input logic last, input int max_gap,
                            input bit is_err, input logic [63:0] hash, output int acc);
      int gap;
      ev_t e;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      if (gap > 0) idle(gap);
      bus.in_valid = 1'b1;
      bus.in_word  = w;
      bus.in_last  = last;
      for (int i = 0; i < 20 && !bus.in_ready; i++) @(negedge clk);
      if (!bus.in_ready) begin
         check_eq("ready_timeout", 64'(bus.in_ready), 64'h1);
         bus.in_valid = 1'b0;
         acc = cyc;
         return;
      end
      acc = cyc;
      if (last) begin
         e.is_err = is_err;
         e.hash   = hash;
         e.cyc    = cyc + (is_err ? 1 : 2);
         exp_q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic send_key(input word_q_t words, input int max_gap,
                           input logic [63:0] hash, output int last_acc);
      bit is_err;
      int acc;
      is_err = words.size() > MAX_WORDS;
      acc = 0;
      foreach (words[i])
         send_word(words[i], i == words.size() - 1, max_gap, is_err, hash, acc);
      last_acc = acc;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      exp_q.delete();
      exp_hash = 64'h0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      word_q_t q;
      int k1, k2, len;

      bus.in_valid = 1'b0;
      bus.in_word  = 32'h0;
      bus.in_last  = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      started = 1'b1;
      check_eq("rst_in_ready", 64'(bus.in_ready), 64'h1);
      check_eq("rst_key_hash", bus.key_hash, 64'h0);
      check_eq("rst_key_en", 64'(bus.key_en), 64'h0);
      check_eq("rst_key_err", 64'(bus.key_err), 64'h0);

      // 1-word zero key; in_ready low exactly two cycles
      q = '{32'h0};
      send_key(q, 0, H_ZERO1, k1);
      bus.in_valid = 1'b0;
      check_eq("t1_ready_T1", 64'(bus.in_ready), 64'h0);
      @(negedge clk);
      check_eq("t1_ready_T2", 64'(bus.in_ready), 64'h0);
      @(negedge clk);
      check_eq("t1_ready_T3", 64'(bus.in_ready), 64'h1);
      idle(2);

      // back-to-back 1-word keys with valid held high
      send_key(q, 0, H_ZERO1, k1);
      send_key(q, 0, H_ZERO1, k2);
      bus.in_valid = 1'b0;
      check_eq("t2_period", 64'(k2 - k1), 64'd3);
      idle(4);

      // exactly MAX_WORDS words
      q = {};
      for (int i = 0; i < MAX_WORDS; i++) q.push_back($urandom);
      send_key(q, 0, ref_hash(q), k1);
      idle(4);

      // overflow, then zero key again
      q = {};
      for (int i = 0; i < 10; i++) q.push_back($urandom);
      send_key(q, 0, 64'h0, k1);
      idle(3);
      q = '{32'h0};
      send_key(q, 0, H_ZERO1, k1);
      idle(4);

      // 3-word key with random gaps
      q = '{$urandom, $urandom, $urandom};
      send_key(q, 3, ref_hash(q), k1);
      idle(4);

      // reset mid-key, then remaining words as a new key
      q = '{$urandom, $urandom, $urandom, $urandom};
      send_word(q[0], 1'b0, 0, 1'b0, 64'h0, k1);
      send_word(q[1], 1'b0, 0, 1'b0, 64'h0, k1);
      pulse_rst();
      check_eq("t6_hash_after_rst", bus.key_hash, 64'h0);
      q = '{q[2], q[3]};
      send_key(q, 0, ref_hash(q), k1);
      idle(4);

      // random keys, including MAX_WORDS+1 with in_last and longer
      for (int n = 0; n < 20; n++) begin
         len = int'($urandom_range(1, MAX_WORDS + 3));
         q = {};
         for (int i = 0; i < len; i++) q.push_back($urandom);
         send_key(q, int'($urandom_range(0, 2)), ref_hash(q), k1);
         idle(int'($urandom_range(0, 2)));
      end

      idle(6);
      check_eq("pending_events", 64'(exp_q.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
